// File: rtl/crossbar_rr.sv
// PORTS x PORTS router crossbar with one round-robin arbiter per output.
// A granted input keeps its output (wormhole lock) for as long as it keeps requesting it.
module crossbar_rr #(
  parameter int PORTS = 4,
  parameter int WIDTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [PORTS*WIDTH-1:0]             data_i,
  input  logic [PORTS-1:0]                   bp_i,
  input  logic [PORTS*$clog2(PORTS)-1:0]     dest,
  input  logic [PORTS-1:0]                   dest_en,
  output logic [PORTS*WIDTH-1:0]             data_o,
  output logic [PORTS-1:0]                   data_o_en,
  output logic [PORTS-1:0]                   bp_o,
  output logic [PORTS-1:0]                   ack
);

  localparam int IW = $clog2(PORTS);

  logic [PORTS-1:0] lock_v_q, lock_v_d;
  logic [IW-1:0]    lock_idx_q [PORTS];
  logic [IW-1:0]    lock_idx_d [PORTS];
  logic [IW-1:0]    ptr_q      [PORTS];
  logic [IW-1:0]    ptr_d      [PORTS];

  logic [PORTS-1:0] req [PORTS];  // req[input][output]
  logic [PORTS-1:0] win_v;
  logic [IW-1:0]    win_idx [PORTS];

  // Out-of-range dest codes never match a valid output, so they request nothing.
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      req[i] = '0;
      for (int o = 0; o < PORTS; o++) begin
        if (dest_en[i] && (int'(dest[i*IW +: IW]) == o)) req[i][o] = 1'b1;
      end
    end
  end

  always_comb begin
    int idx;
    idx = 0;
    for (int o = 0; o < PORTS; o++) begin
      win_v[o]   = 1'b0;
      win_idx[o] = '0;
      if (lock_v_q[o] && req[lock_idx_q[o]][o]) begin
        win_v[o]   = 1'b1;
        win_idx[o] = lock_idx_q[o];
      end else begin
        for (int k = 0; k < PORTS; k++) begin
          idx = int'(ptr_q[o]) + k;
          if (idx >= PORTS) idx = idx - PORTS;
          if (!win_v[o] && req[idx][o]) begin
            win_v[o]   = 1'b1;
            win_idx[o] = IW'(idx);
          end
        end
      end
    end
  end

  // The pointer only moves on a fresh grant, so a held lock does not advance it.
  always_comb begin
    int nx;
    nx = 0;
    for (int o = 0; o < PORTS; o++) begin
      lock_v_d[o]   = win_v[o];
      lock_idx_d[o] = win_v[o] ? win_idx[o] : lock_idx_q[o];
      ptr_d[o]      = ptr_q[o];
      if (win_v[o] && !(lock_v_q[o] && (lock_idx_q[o] == win_idx[o]))) begin
        nx = int'(win_idx[o]) + 1;
        if (nx >= PORTS) nx = 0;
        ptr_d[o] = IW'(nx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_v_q <= '0;
      for (int o = 0; o < PORTS; o++) begin
        lock_idx_q[o] <= '0;
        ptr_q[o]      <= '0;
      end
    end else begin
      lock_v_q <= lock_v_d;
      for (int o = 0; o < PORTS; o++) begin
        lock_idx_q[o] <= lock_idx_d[o];
        ptr_q[o]      <= ptr_d[o];
      end
    end
  end

  // Outputs are held at zero for as long as reset is asserted.
  always_comb begin
    data_o    = '0;
    data_o_en = '0;
    bp_o      = '0;
    ack       = '0;
    if (rst) begin
      for (int o = 0; o < PORTS; o++) begin
        if (win_v[o]) begin
          data_o[o*WIDTH +: WIDTH] = data_i[int'(win_idx[o])*WIDTH +: WIDTH];
          data_o_en[o]             = 1'b1;
          ack[win_idx[o]]          = 1'b1;
          bp_o[win_idx[o]]         = bp_i[o];
        end
      end
    end
  end

endmodule

// File: tb/tb_crossbar_rr.sv
// Directed bench for crossbar_rr: a vector table plus hand-written multi-cycle sequences.
module tb_crossbar_rr;

  logic        clk;
  logic        rst;
  logic [31:0] data_i;
  logic [3:0]  bp_i;
  logic [7:0]  dest;
  logic [3:0]  dest_en;
  logic [31:0] data_o;
  logic [3:0]  data_o_en;
  logic [3:0]  bp_o;
  logic [3:0]  ack;

  int n_checks = 0;
  int n_fail   = 0;

  crossbar_rr #(.PORTS(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .bp_i      (bp_i),
    .dest      (dest),
    .dest_en   (dest_en),
    .data_o    (data_o),
    .data_o_en (data_o_en),
    .bp_o      (bp_o),
    .ack       (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  en;
    logic [7:0]  dst;
    logic [31:0] dat;
    logic [3:0]  bp;
    logic [31:0] exp_data;
    logic [3:0]  exp_en;
    logic [3:0]  exp_bp;
    logic [3:0]  exp_ack;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check4(input string name, input logic [31:0] e_data, input logic [3:0] e_en,
                        input logic [3:0] e_bp, input logic [3:0] e_ack);
    chk({name, ".data_o"},    data_o,           e_data);
    chk({name, ".data_o_en"}, {28'd0, data_o_en}, {28'd0, e_en});
    chk({name, ".bp_o"},      {28'd0, bp_o},      {28'd0, e_bp});
    chk({name, ".ack"},       {28'd0, ack},       {28'd0, e_ack});
  endtask

  // Drive a new input set after the falling edge; outputs settle 1 time unit later.
  task automatic apply(input logic [3:0] en, input logic [7:0] dst, input logic [31:0] dat,
                       input logic [3:0] bp);
    @(negedge clk);
    dest_en = en;
    dest    = dst;
    data_i  = dat;
    bp_i    = bp;
    #1;
    $display("t=%0t en=%b dest=%h data_i=%h bp_i=%b -> data_o=%h en_o=%b bp_o=%b ack=%b",
             $time, en, dst, dat, bp, data_o, data_o_en, bp_o, ack);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b0;
    dest_en = 4'b0000;
    @(negedge clk);
    rst     = 1'b1;
  endtask

  int prev;
  int expw;

  initial begin
    vecs[0] = '{"idle",       4'b0000, 8'h00, 32'h0000_0000, 4'b0000,
                32'h0000_0000, 4'b0000, 4'b0000, 4'b0000};
    vecs[1] = '{"in0_to_out2", 4'b0001, 8'h02, 32'h0000_00A5, 4'b0100,
                32'h00A5_0000, 4'b0100, 4'b0001, 4'b0001};
    vecs[2] = '{"in0_bp_low", 4'b0001, 8'h02, 32'h0000_00A5, 4'b0000,
                32'h00A5_0000, 4'b0100, 4'b0000, 4'b0001};
    vecs[3] = '{"permutation", 4'b1111, 8'h39, 32'h4433_2211, 4'b1010,
                32'h3322_1144, 4'b1111, 4'b0101, 4'b1111};

    rst     = 1'b0;
    dest_en = 4'b1111;
    dest    = 8'h39;
    data_i  = 32'hFFEE_DDCC;
    bp_i    = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check4("reset_held", 32'h0, 4'b0000, 4'b0000, 4'b0000);
    rst     = 1'b1;
    dest_en = 4'b0000;
    #1;
    check4("after_reset", 32'h0, 4'b0000, 4'b0000, 4'b0000);

    for (int v = 0; v < 4; v++) begin
      apply(vecs[v].en, vecs[v].dst, vecs[v].dat, vecs[v].bp);
      check4(vecs[v].name, vecs[v].exp_data, vecs[v].exp_en, vecs[v].exp_bp, vecs[v].exp_ack);
    end

    // Inputs 1 and 3 contend for output 0; input 1 wins from ptr=0 and holds.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      apply(4'b1010, 8'h00, 32'h4433_2211, 4'b0001);
      check4("contend_in1_holds", 32'h0000_0022, 4'b0001, 4'b0010, 4'b0010);
    end
    apply(4'b1000, 8'h00, 32'h4433_2211, 4'b0001);
    check4("in1_release_in3_wins", 32'h0000_0044, 4'b0001, 4'b1000, 4'b1000);
    for (int c = 0; c < 2; c++) begin
      apply(4'b1001, 8'h00, 32'h4433_2211, 4'b0001);
      check4("in3_lock_beats_in0", 32'h0000_0044, 4'b0001, 4'b1000, 4'b1000);
    end
    apply(4'b0001, 8'h00, 32'h4433_2211, 4'b0001);
    check4("in3_release_in0_wins", 32'h0000_0011, 4'b0001, 4'b0001, 4'b0001);

    // All inputs re-request output 1; the previous winner drops for one cycle.
    do_reset();
    prev = -1;
    for (int s = 0; s < 5; s++) begin
      logic [3:0] en;
      en = 4'b1111;
      if (prev >= 0) en[prev] = 1'b0;
      expw = s % 4;
      apply(en, 8'h55, 32'h4433_2211, 4'b0010);
      check4($sformatf("rr_step%0d", s), (32'h11 * (expw + 1)) << 8, 4'b0010,
             4'b0001 << expw, 4'b0001 << expw);
      prev = expw;
    end
    apply(4'b1110, 8'h55, 32'h4433_2211, 4'b0010);
    chk("rr_in1_after_in0", {28'd0, ack}, 32'h2);
    apply(4'b1111, 8'h55, 32'h4433_2211, 4'b0010);
    chk("lock_in1_held", {28'd0, ack}, 32'h2);

    // Asynchronous reset mid-packet: outputs drop at once, arbitration restarts from ptr=0.
    #2;
    rst = 1'b0;
    #1;
    check4("midpkt_reset", 32'h0, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check4("post_reset_ptr0", 32'h0000_1100, 4'b0010, 4'b0001, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crossbar_rr.md
Name: crossbar_rr

Overview:
- PORTS x PORTS switch between router input ports and output ports, one per node.
- Each input requests one output. A per-output round-robin arbiter picks one requester.
- The winning input's data goes to that output, and the output's backpressure/ack returns to the winning input.
- Once granted, an input keeps its output until it stops requesting it (wormhole lock).

Parameters:
- PORTS, 4, number of input and output ports (N, E, S, W; e_dir encoding from noc_types).
- WIDTH, 8, data width per port in bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_i  in  PORTS x WIDTH  data from each input port.
- bp_i  in  PORTS x 1  ack/backpressure from each output's downstream receiver (1 = accepted).
- dest  in  PORTS x $clog2(PORTS)  requested output index (e_dir) for each input.
- dest_en  in  PORTS x 1  input i requests output dest[i].
- data_o  out  PORTS x WIDTH  data driven to each output.
- data_o_en  out  PORTS x 1  output o carries valid data this cycle.
- bp_o  out  PORTS x 1  ack returned to each input: bp_i of its granted output.
- ack  out  PORTS x 1  input i currently holds a grant.

Behaviour:
- State per output o:
  - lock_v[o] (1 bit), lock_idx[o] ($clog2(PORTS)) and ptr[o] ($clog2(PORTS)).
  - No other state.
- Reset (rst=0, async):
  - lock_v=0, ptr=0.
  - While reset is held, all outputs are forced to 0: data_o, data_o_en, bp_o, ack.
- Request: req[i][o] = dest_en[i] && dest[i]==o.
- Grant for output o, combinational, evaluated in the same cycle:
  - If lock_v[o] and req[lock_idx[o]][o] are both true, the winner is lock_idx[o].
  - Otherwise the winner is the first requester found scanning i = ptr[o], ptr[o]+1, ... modulo PORTS.
  - If there are no requesters, there is no winner.
- Outputs, all combinational from the winner (zero cycles latency):
  - Winner w on output o: data_o[o]=data_i[w], data_o_en[o]=1, ack[w]=1, bp_o[w]=bp_i[o].
  - No winner on output o: data_o[o]=0, data_o_en[o]=0.
  - Input not granted: ack=0, bp_o=0.
- Each input requests exactly one output, so each input has at most one grant.
- Sequential update per output o, on the rising clock edge:
  - Winner w exists: lock_v<=1, lock_idx<=w. If the lock was not previously held by w, ptr<=(w+1) mod PORTS.
  - No winner: lock_v<=0; ptr is unchanged.
- Lock release:
  - Holder deasserts dest_en or changes dest: the lock is void that cycle and arbitration re-runs from ptr in the same cycle.
  - The releasing input is therefore lowest priority immediately.
- Simultaneous requests: only one input wins per output. Losers see ack=0 and bp_o=0 and must hold their request.
- Requests to different outputs are independent and are all granted in the same cycle (full permutation).
- Reset asserted mid-packet: locks drop at once. After reset, arbitration restarts from ptr=0.
- dest values >= PORTS (only possible when PORTS is not a power of 2) are treated as no request.

Test Plan:
- Reset held (rst=0) with every input requesting -> every output is 0; after release with no requests, data_o_en=0 and ack=0.
- Input 0 requests output 2, data 0xA5, bp_i[2]=1 -> same cycle: data_o[2]=0xA5, data_o_en[2]=1, ack[0]=1, bp_o[0]=1. With bp_i[2]=0 -> bp_o[0]=0 while ack[0] stays 1.
- Inputs 1 and 3 both request output 0 from reset (ptr=0) -> input 1 wins. Input 1 holds for 3 cycles, input 3 has ack=0. Input 1 drops -> input 3 is granted that same cycle.
- Lock priority: input 3 is locked on output 0 and input 0 also requests output 0 -> input 3 keeps the grant until it releases.
- Round-robin fairness: inputs 0..3 all continuously re-request output 1, each releasing after a 1-cycle grant -> grants rotate 0,1,2,3,0.
- Permutation: dest = {1,2,3,0} from inputs 0..3 -> all four acks=1 and data_o[k]=data_i[(k+3) mod 4] in the same cycle.
